// File: rtl/p_ssync_nd_filt.sv
// Purpose : per-channel N-stage synchroniser into clk with optional glitch filter and edge pulses.
// Latency : d->q = STAGES edges (FILT=0) or STAGES+FILT+1 edges (FILT>0); pulse in the cycle q changes.
// Backpr. : none; d is sampled on every clk edge and outputs are never stalled.
//
// Ports:
//   clk   - destination clock
//   rst   - asynchronous, active-high reset (loads RST_VAL into chain, q and history)
//   d     - asynchronous inputs, one independent channel per bit
//   q     - synchronised (and filtered) level per channel
//   pulse - one-cycle event per channel on the q edge(s) chosen by EDGE
//   busy  - per channel, filter counter non-zero (a change is being qualified)
module p_ssync_nd_filt #(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               FILT    = 0,
  parameter int               EDGE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] pulse,
  output logic [WIDTH-1:0] busy
);

  // Elaboration-time guard on the parameter space.
  if (STAGES < 2 || STAGES > 8 || EDGE < 0 || EDGE > 3 || FILT < 0) begin : g_bad_param
    $fatal(1, "p_ssync_nd_filt: illegal parameters STAGES=%0d EDGE=%0d FILT=%0d",
           STAGES, EDGE, FILT);
  end

  localparam logic RISE_EN = (EDGE == 1) || (EDGE == 3);
  localparam logic FALL_EN = (EDGE == 2) || (EDGE == 3);

  // Synchroniser chain; every stage is a plain flop with no enable.
  logic [WIDTH-1:0] s [STAGES];
  logic [WIDTH-1:0] s_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        s[k] <= RST_VAL;
      end
    end else begin
      s[0] <= d;
      for (int k = 1; k < STAGES; k++) begin
        s[k] <= s[k-1];
      end
    end
  end

  assign s_out = s[STAGES-1];

  if (FILT == 0) begin : g_nofilt
    assign q    = s_out;
    assign busy = '0;
  end else begin : g_filt
    localparam int            CW   = $clog2(FILT + 1);
    localparam logic [CW-1:0] CMAX = CW'(FILT);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic          q_r;
      logic [CW-1:0] cnt;

      // The counter only advances while s_out disagrees with q; any return to
      // agreement clears it, so short glitches never accumulate.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_r <= RST_VAL[i];
          cnt <= '0;
        end else if (s_out[i] == q_r) begin
          cnt <= '0;
        end else if (cnt == CMAX) begin
          q_r <= s_out[i];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign q[i]    = q_r;
      assign busy[i] = (cnt != '0);
    end
  end

  // History flop resets to RST_VAL as well, so neither reset assertion nor
  // release can fabricate an edge.
  logic [WIDTH-1:0] h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= RST_VAL;
    end else begin
      h <= q;
    end
  end

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  assign rise  = q & ~h;
  assign fall  = ~q & h;
  assign pulse = (rise & {WIDTH{RISE_EN}}) | (fall & {WIDTH{FALL_EN}});

endmodule

// File: tb/tb_p_ssync_nd_filt.sv
// Scoreboarded bench for p_ssync_nd_filt: four instances with different parameter
// sets; stimulus pushes expected pulse events, a negedge monitor matches them.
module tb_p_ssync_nd_filt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst;

  // u1: WIDTH=1 STAGES=3 FILT=0 EDGE=1
  logic       d1, q1, p1, b1;
  // u2: WIDTH=1 STAGES=3 FILT=2 EDGE=1
  logic       d2, q2, p2, b2;
  // u3: WIDTH=4 STAGES=3 FILT=0 EDGE=3 RST_VAL=4'hA
  logic [3:0] d3, q3, p3, b3;
  // u4: WIDTH=1 STAGES=8 FILT=0 EDGE=2
  logic       d4, q4, p4, b4;

  p_ssync_nd_filt #(.WIDTH(1), .STAGES(3), .RST_VAL(1'b0), .FILT(0), .EDGE(1)) u1 (
    .clk(clk), .rst(rst[0]), .d(d1), .q(q1), .pulse(p1), .busy(b1));
  p_ssync_nd_filt #(.WIDTH(1), .STAGES(3), .RST_VAL(1'b0), .FILT(2), .EDGE(1)) u2 (
    .clk(clk), .rst(rst[1]), .d(d2), .q(q2), .pulse(p2), .busy(b2));
  p_ssync_nd_filt #(.WIDTH(4), .STAGES(3), .RST_VAL(4'hA), .FILT(0), .EDGE(3)) u3 (
    .clk(clk), .rst(rst[2]), .d(d3), .q(q3), .pulse(p3), .busy(b3));
  p_ssync_nd_filt #(.WIDTH(1), .STAGES(8), .RST_VAL(1'b0), .FILT(0), .EDGE(2)) u4 (
    .clk(clk), .rst(rst[3]), .d(d4), .q(q4), .pulse(p4), .busy(b4));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         inst;
    int         cyc;
    logic [3:0] q;
    logic [3:0] p;
  } exp_t;

  exp_t sbq[$];
  int   nchk  = 0;
  int   nfail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)", nm, act, exp, $time, cyc);
    end
  endtask

  task automatic expect_pulse(input int inst, input int at, input logic [3:0] qv,
                              input logic [3:0] pv);
    exp_t e;
    e.inst = inst;
    e.cyc  = at;
    e.q    = qv;
    e.p    = pv;
    sbq.push_back(e);
  endtask

  // Advance to 2 time units after the n-th next falling edge (inputs change there).
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Monitor: every non-zero pulse must match the oldest pending entry of its instance.
  always @(negedge clk) begin : mon
    logic [3:0] qv [4];
    logic [3:0] pv [4];
    int         k;
    qv[0] = {3'b0, q1}; pv[0] = {3'b0, p1};
    qv[1] = {3'b0, q2}; pv[1] = {3'b0, p2};
    qv[2] = q3;         pv[2] = p3;
    qv[3] = {3'b0, q4}; pv[3] = {3'b0, p4};
    for (int i = 0; i < 4; i++) begin
      if (pv[i] != 4'h0) begin
        k = -1;
        for (int j = 0; j < sbq.size(); j++) begin
          if (k < 0 && sbq[j].inst == i) k = j;
        end
        if (k < 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_pulse u%0d: got pulse=%h q=%h expected none (cyc=%0d)",
                   i + 1, pv[i], qv[i], cyc);
        end else begin
          chk($sformatf("pulse_cycle_u%0d", i + 1), cyc, sbq[k].cyc);
          chk($sformatf("pulse_val_u%0d", i + 1), int'(pv[i]), int'(sbq[k].p));
          chk($sformatf("pulse_q_u%0d", i + 1), int'(qv[i]), int'(sbq[k].q));
          sbq.delete(k);
        end
      end
    end
  end

  initial begin : stim
    int d0;
    rst = 4'h0;
    d1 = 1'b0; d2 = 1'b0; d3 = 4'hA; d4 = 1'b0;
    #1 rst = 4'hF;
    step(3);

    // Reset state
    chk("rst_q1", q1, 0);
    chk("rst_p1", p1, 0);
    chk("rst_q2", q2, 0);
    chk("rst_busy2", b2, 0);
    chk("rst_q3", q3, 4'hA);
    chk("rst_p3", p3, 0);
    chk("rst_q4", q4, 0);
    rst = 4'h0;
    step(6);
    chk("release_q3", q3, 4'hA);

    // Rising edge through a 3-stage chain, no filter
    d0 = cyc; d1 = 1'b1;
    expect_pulse(0, d0 + 3, 4'h1, 4'h1);
    step(2); chk("t1_q_early", q1, 0);
    step(1); chk("t1_q", q1, 1);
    d1 = 1'b0;                     // falling edge: no pulse with EDGE=1
    step(5); chk("t1_fall_q", q1, 0);

    // Two-cycle glitch against FILT=2 is rejected; busy for two cycles
    d0 = cyc; d2 = 1'b1;
    step(2); d2 = 1'b0;
    for (int i = 3; i <= 7; i++) begin
      step(1);
      chk($sformatf("t2_busy_%0d", i), b2, int'(i == 4 || i == 5));
      chk($sformatf("t2_q_%0d", i), q2, 0);
    end

    // Held change qualifies after STAGES+FILT+1 edges
    d0 = cyc; d2 = 1'b1;
    expect_pulse(1, d0 + 6, 4'h1, 4'h1);
    step(5); chk("t2_hold_q_early", q2, 0); chk("t2_hold_busy", b2, 1);
    step(1); chk("t2_hold_q", q2, 1);       chk("t2_hold_busy_clr", b2, 0);
    d2 = 1'b0;
    step(8); chk("t2_fall_q", q2, 0);

    // Four channels, both edges
    d0 = cyc; d3 = 4'h5;
    expect_pulse(2, d0 + 3, 4'h5, 4'hF);
    step(3); chk("t3_q_5", q3, 4'h5);
    d0 = cyc; d3 = 4'h6;
    expect_pulse(2, d0 + 3, 4'h6, 4'h3);
    step(4); chk("t3_q_6", q3, 4'h6);

    // 8-stage chain, falling-edge pulses only
    d0 = cyc; d4 = 1'b1;
    step(7); chk("t4_rise_q_early", q4, 0);
    step(1); chk("t4_rise_q", q4, 1);
    d0 = cyc; d4 = 1'b0;
    expect_pulse(3, d0 + 8, 4'h0, 4'h1);
    step(8); chk("t4_fall_q", q4, 0);
    step(2);

    // Reset with a change two stages into the chain: change is lost
    d1 = 1'b1;
    step(2);
    rst[0] = 1'b1; d1 = 1'b0;
    #1; chk("t5_q1_async", q1, 0); chk("t5_p1_async", p1, 0);
    step(1); rst[0] = 1'b0;
    step(6); chk("t5_q1_after", q1, 0);

    // Reset while q holds a non-reset value: q snaps back asynchronously, no pulse
    d3 = 4'hA; rst[2] = 1'b1;
    #1; chk("t5_q3_async", q3, 4'hA); chk("t5_p3_async", p3, 0);
    step(1); rst[2] = 1'b0;
    step(5); chk("t5_q3_after", q3, 4'hA);

    // Reset mid-count clears busy asynchronously
    d0 = cyc; d2 = 1'b1;
    step(4); chk("t5_busy2_pre", b2, 1);
    rst[1] = 1'b1; d2 = 1'b0;
    #1; chk("t5_busy2_async", b2, 0); chk("t5_q2_async", q2, 0);
    step(1); rst[1] = 1'b0;
    step(10); chk("t5_q2_after", q2, 0); chk("t5_busy2_after", b2, 0);

    chk("sb_pending", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
